// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester/broadcast bundle shared by the functional units and the CDB arbiter
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 2
`endif

interface cdb_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int XLEN         = `XLEN,
  parameter int TAG_W        = `ROB_SIZE,
  parameter int THREAD_WIDTH = `THREAD_WIDTH
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_i;
  logic [NUM_REQ*TAG_W-1:0]        req_tag_i;
  logic [NUM_REQ*XLEN-1:0]         req_value_i;
  logic [NUM_REQ*THREAD_WIDTH-1:0] req_thread_i;
  logic [NUM_REQ-1:0]              gnt_o;
  logic                            cdb_valid_o;
  logic [TAG_W-1:0]                cdb_tag_o;
  logic [XLEN-1:0]                 cdb_value_o;
  logic [THREAD_WIDTH-1:0]         cdb_thread_o;
  logic [SRC_W-1:0]                cdb_src_o;

  modport master (
    output req_i, req_tag_i, req_value_i, req_thread_i,
    input  gnt_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_thread_o, cdb_src_o
  );

  modport slave (
    input  req_i, req_tag_i, req_value_i, req_thread_i,
    output gnt_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_thread_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with one-cycle registered broadcast
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 2
`endif

module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int XLEN         = `XLEN,
  parameter int TAG_W        = `ROB_SIZE,
  parameter int THREAD_WIDTH = `THREAD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [THREAD_WIDTH-1:0] flush_thread_i,
  cdb_arbiter_if.slave            bus
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      flush_mask;
  logic [NUM_REQ-1:0]      elig;
  logic [SRC_W-1:0]        rr_ptr;
  logic [SRC_W-1:0]        ptr_next;
  logic [SRC_W-1:0]        win;
  logic                    found;
  int                      idx;

  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic [THREAD_WIDTH-1:0] cdb_thread;
  logic [SRC_W-1:0]        cdb_src;

  // Requests from the thread being flushed are wrong-path results and never reach the bus.
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      flush_mask[i] = flush_i &&
                      (bus.req_thread_i[i*THREAD_WIDTH +: THREAD_WIDTH] == flush_thread_i);
    end
    elig = bus.req_i & ~flush_mask & {NUM_REQ{~stall_i}};
  end

  // Scan upward from rr_ptr with wrap; the first eligible requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SRC_W-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it becomes the lowest priority next time.
  always_comb begin
    ptr_next = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
  end

  // Grant is combinational and held off entirely while reset is asserted.
  assign bus.gnt_o = (found && rst) ? (NUM_REQ'(1) << win) : '0;

  // Broadcast register: valid only for the cycle after a grant. A flushed thread can never
  // win, so a stale broadcast of that thread is never re-asserted after the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_thread <= '0;
      cdb_src    <= '0;
      rr_ptr     <= '0;
    end else begin
      cdb_valid <= found;
      if (found) begin
        cdb_tag    <= bus.req_tag_i[int'(win)*TAG_W +: TAG_W];
        cdb_value  <= bus.req_value_i[int'(win)*XLEN +: XLEN];
        cdb_thread <= bus.req_thread_i[int'(win)*THREAD_WIDTH +: THREAD_WIDTH];
        cdb_src    <= win;
        rr_ptr     <= ptr_next;
      end
    end
  end

  assign bus.cdb_valid_o  = cdb_valid;
  assign bus.cdb_tag_o    = cdb_tag;
  assign bus.cdb_value_o  = cdb_value;
  assign bus.cdb_thread_o = cdb_thread;
  assign bus.cdb_src_o    = cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
  localparam int N   = 4;
  localparam int XL  = 32;
  localparam int TW  = 6;
  localparam int THW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic [THW-1:0] flush_thr = '0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .XLEN(XL), .TAG_W(TW), .THREAD_WIDTH(THW)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .XLEN(XL), .TAG_W(TW), .THREAD_WIDTH(THW)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .flush_i        (flush),
    .flush_thread_i (flush_thr),
    .bus            (bus)
  );

  // Requester-side view of each functional unit.
  logic           r_req [N];
  logic [TW-1:0]  r_tag [N];
  logic [XL-1:0]  r_val [N];
  logic [THW-1:0] r_thr [N];

  // Reference model state.
  int             m_ptr;
  logic           m_valid;
  logic [TW-1:0]  m_tag;
  logic [XL-1:0]  m_val;
  logic [THW-1:0] m_thr;
  int             m_src;
  int             last_w;

  int n_vec = 0;
  int n_err = 0;
  int waitc [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_i[i]                    = r_req[i];
      bus.req_tag_i[i*TW +: TW]       = r_tag[i];
      bus.req_value_i[i*XL +: XL]     = r_val[i];
      bus.req_thread_i[i*THW +: THW]  = r_thr[i];
    end
  endtask

  task automatic set_req(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) r_req[i] = m[i];
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r_req[i] && !stall && !(flush && r_thr[i] == flush_thr)) return i;
    end
    return -1;
  endfunction

  // One clock cycle: entered just after a rising edge, returns just after the next one.
  task automatic cycle(input bit en, input logic [N-1:0] eg);
    int         w;
    logic [N-1:0] mg;
    apply();
    #3;
    w  = model_winner();
    mg = (w < 0) ? '0 : (N'(1) << w);
    chk("gnt", {60'd0, bus.gnt_o}, {60'd0, mg});
    if (en) chk("gnt_directed", {60'd0, bus.gnt_o}, {60'd0, eg});
    chk("cdb_valid", {63'd0, bus.cdb_valid_o}, {63'd0, m_valid});
    if (m_valid) begin
      chk("cdb_tag", 64'(bus.cdb_tag_o), 64'(m_tag));
      chk("cdb_value", 64'(bus.cdb_value_o), 64'(m_val));
      chk("cdb_thread", 64'(bus.cdb_thread_o), 64'(m_thr));
      chk("cdb_src", 64'(bus.cdb_src_o), 64'(m_src));
    end
    last_w = w;
    @(posedge clk);
    if (w >= 0) begin
      m_valid = 1'b1;
      m_tag   = r_tag[w];
      m_val   = r_val[w];
      m_thr   = r_thr[w];
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.cdb_valid_o), 64'd0);
    chk("rst_tag", 64'(bus.cdb_tag_o), 64'd0);
    chk("rst_value", 64'(bus.cdb_value_o), 64'd0);
    chk("rst_thread", 64'(bus.cdb_thread_o), 64'd0);
    chk("rst_src", 64'(bus.cdb_src_o), 64'd0);
    set_req(4'b1111);
    apply();
    #1;
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_val = '0; m_thr = '0; m_src = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      r_req[i] = 1'b0; r_tag[i] = '0; r_val[i] = '0; r_thr[i] = '0; waitc[i] = 0;
    end
    apply();
    @(posedge clk);
    #1;
    do_reset();

    // Single request.
    r_tag[1] = 6'd5; r_val[1] = 32'h100; r_thr[1] = 2'd0;
    set_req(4'b0010);
    cycle(1, 4'b0010);
    chk("single_valid", 64'(bus.cdb_valid_o), 64'd1);
    chk("single_tag", 64'(bus.cdb_tag_o), 64'd5);
    chk("single_value", 64'(bus.cdb_value_o), 64'h100);
    chk("single_src", 64'(bus.cdb_src_o), 64'd1);
    set_req(4'b0000);
    cycle(1, 4'b0000);

    // All four requesting after reset rotate 0,1,2,3,0...
    do_reset();
    for (int i = 0; i < N; i++) begin r_tag[i] = TW'(i + 8); r_val[i] = XL'(i * 16 + 3); end
    set_req(4'b1111);
    for (int c = 0; c < 8; c++) begin
      cycle(1, 4'b0001 << (c % 4));
      chk("rr_src", 64'(bus.cdb_src_o), 64'(c % 4));
    end
    set_req(4'b0000);
    cycle(1, 4'b0000);

    // Stall blocks grants; release resumes at index 0 then 2.
    do_reset();
    set_req(4'b0101);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(1, 4'b0000);
      chk("stall_valid", 64'(bus.cdb_valid_o), 64'd0);
    end
    stall = 1'b0;
    cycle(1, 4'b0001);
    set_req(4'b0100);
    cycle(1, 4'b0100);
    set_req(4'b0000);
    cycle(1, 4'b0000);

    // Flush of thread 1 masks requester 0 and kills its pending broadcast.
    do_reset();
    r_thr[0] = 2'd1; r_thr[1] = 2'd0;
    set_req(4'b0001);
    cycle(1, 4'b0001);
    chk("pre_flush_thread", 64'(bus.cdb_thread_o), 64'd1);
    set_req(4'b0011);
    flush = 1'b1; flush_thr = 2'd1;
    cycle(1, 4'b0010);
    chk("flush_other_thread", 64'(bus.cdb_thread_o), 64'd0);
    flush = 1'b0;
    set_req(4'b0001);
    cycle(1, 4'b0001);
    flush = 1'b1;
    cycle(1, 4'b0000);
    chk("flush_clears_valid", 64'(bus.cdb_valid_o), 64'd0);
    stall = 1'b1;
    set_req(4'b0011);
    cycle(1, 4'b0000);
    stall = 1'b0; flush = 1'b0;
    set_req(4'b0000);
    cycle(1, 4'b0000);

    // Pointer wrap from 3 back to 0.
    do_reset();
    set_req(4'b0100);
    cycle(1, 4'b0100);
    set_req(4'b1001);
    cycle(1, 4'b1000);
    set_req(4'b0001);
    cycle(1, 4'b0001);
    set_req(4'b0000);

    // Reset during an active broadcast, then restart from index 0.
    set_req(4'b0010);
    cycle(1, 4'b0010);
    chk("pre_reset_valid", 64'(bus.cdb_valid_o), 64'd1);
    do_reset();
    set_req(4'b1100);
    cycle(1, 4'b0100);
    set_req(4'b0000);
    cycle(1, 4'b0000);

    // Randomized traffic with requesters that hold until granted or flushed.
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int it = 0; it < 400; it++) begin
      logic           f;
      logic [THW-1:0] ft;
      stall     = ($urandom % 8) == 0;
      flush     = ($urandom % 6) == 0;
      flush_thr = THW'($urandom);
      f = flush; ft = flush_thr;
      for (int i = 0; i < N; i++)
        if (r_req[i] && !stall && !(f && r_thr[i] == ft)) waitc[i]++;
      cycle(0, 4'b0000);
      for (int i = 0; i < N; i++) begin
        if (last_w == i) begin
          chk("fairness", 64'(waitc[i] <= N), 64'd1);
          waitc[i] = 0;
        end
        if (!r_req[i] || last_w == i || (f && r_thr[i] == ft)) begin
          r_req[i] = ($urandom % 4) != 0;
          r_tag[i] = TW'($urandom);
          r_val[i] = XL'($urandom);
          r_thr[i] = THW'($urandom);
          waitc[i] = 0;
        end
      end
    end
    stall = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of functional-unit requesters (ALU, branch, load/store, mul) sharing the CDB.
REQ-002 Parameter XLEN, default `XLEN: result value width.
REQ-003 Parameter TAG_W, default `ROB_SIZE: ROB tag width.
REQ-004 Parameter THREAD_WIDTH, default `THREAD_WIDTH: thread-id width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stall_i  in  1  global pipeline stall; blocks all grants.
REQ-008 flush_i  in  1  mispredict flush for one thread.
REQ-009 flush_thread_i  in  THREAD_WIDTH  thread being flushed.
REQ-010 req_i  in  NUM_REQ  per-requester result-ready request.
REQ-011 req_tag_i  in  NUM_REQ*TAG_W  packed per-requester ROB tags; slice i at [i*TAG_W +: TAG_W].
REQ-012 req_value_i  in  NUM_REQ*XLEN  packed per-requester result values.
REQ-013 req_thread_i  in  NUM_REQ*THREAD_WIDTH  packed per-requester thread ids.
REQ-014 gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as winning request.
REQ-015 cdb_valid_o  out  1  registered broadcast valid.
REQ-016 cdb_tag_o / cdb_value_o / cdb_thread_o  out  TAG_W / XLEN / THREAD_WIDTH  registered broadcast payload.
REQ-017 cdb_src_o  out  $clog2(NUM_REQ)  index of requester that produced current broadcast.

Function
REQ-018 Requester i SHALL hold req_i[i] and its tag/value/thread stable until the cycle gnt_o[i]=1; it drops or replaces them the following cycle.
REQ-019 Eligible set = req_i & ~flush_mask & {NUM_REQ{~stall_i}}; flush_mask[i]=flush_i && req_thread_i[i]==flush_thread_i.
REQ-020 At most one gnt_o bit SHALL be set per cycle; gnt_o=0 when eligible set empty.
REQ-021 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, increasing index with wrap from NUM_REQ-1 to 0; first eligible wins.
REQ-022 rr_ptr SHALL update to (winner+1) mod NUM_REQ on the edge ending a granted cycle; unchanged when no grant.
REQ-023 Latency: the winner's payload SHALL appear on cdb_* with cdb_valid_o=1 exactly one cycle after its grant cycle.
REQ-024 No grant in a cycle -> cdb_valid_o=0 next cycle; payload registers hold prior values (don't-care).
REQ-025 Fairness: a continuously-requesting, non-flushed requester SHALL be granted within NUM_REQ unstalled cycles.
REQ-026 Flush SHALL also clear cdb_valid_o on the next edge if the registered broadcast's cdb_thread_o equals flush_thread_i; broadcasts of other threads unaffected.
REQ-027 Flushed requesters get no grant; requester is expected to drop its request (no retained state in arbiter).
REQ-028 stall_i and flush_i together: no grant; flush clearing per REQ-026 still applies.
REQ-029 cdb_src_o SHALL equal the index of the granted requester, registered with payload.

Reset
REQ-030 rst=0 SHALL asynchronously force cdb_valid_o=0, cdb_tag_o=0, cdb_value_o=0, cdb_thread_o=0, cdb_src_o=0, rr_ptr=0.
REQ-031 gnt_o SHALL be 0 while rst=0 regardless of req_i.
REQ-032 Reset asserted mid-broadcast SHALL drop the broadcast; after release, arbitration restarts from index 0.

Verification
REQ-033 Single request: req_i=0010, tag=5, value=0x100 -> gnt_o=0010 same cycle; next cycle cdb_valid_o=1, tag=5, value=0x100, src=1.
REQ-034 Round-robin: req_i=1111 held 8 cycles after reset -> grants 0001,0010,0100,1000,0001,... ; cdb_src_o sequence 0,1,2,3,0 one cycle delayed.
REQ-035 Stall: req_i=0101, stall_i=1 for 3 cycles -> gnt_o=0, cdb_valid_o=0; stall release -> gnt_o=0001 first, then 0100.
REQ-036 Flush: req0 thread 1, req1 thread 0, flush_i=1 flush_thread_i=1 -> gnt_o=0010; broadcast of thread 1 registered prior cycle -> cdb_valid_o cleared.
REQ-037 Wrap: rr_ptr=3, req_i=1001 -> gnt_o=1000, then rr_ptr=0, gnt_o=0001.
REQ-038 Reset mid-run: rst low during active broadcast -> cdb_valid_o=0 immediately; after release with req_i=1100 -> first grant 0100.
